// File: rtl/fetch_redirect_arb_pkg.sv
// Shared frontend definitions for redirect arbitration: source encodings,
// FSM states and the target-to-cacheline slice rule.
package fetch_redirect_arb_pkg;

  localparam logic [1:0] SRC_ROB = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_D1  = 2'd2;
  localparam logic [1:0] SRC_RAS = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SQUASH = 2'd2
  } fsm_state_e;

  // The cacheline counter is the upper clc_w bits of an xlen-wide target.
  function automatic int clc_lsb(input int xlen, input int clc_w);
    return xlen - clc_w;
  endfunction

  function automatic logic [63:0] clc_slice(input logic [63:0] target, input int lsb);
    return target >> lsb;
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Masked fixed-priority select over the four redirect sources
// (ROB > BR > D1 > RAS); purely combinational.
module redirect_prio_sel
  import fetch_redirect_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            rob_valid,
  input  logic [XLEN-1:0] rob_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            d1_valid,
  input  logic [XLEN-1:0] d1_target,
  input  logic            ras_valid,
  input  logic [XLEN-1:0] ras_target,
  input  logic            mask_low,
  input  logic            mask_br,
  output logic            sel_valid,
  output logic [1:0]      sel_src,
  output logic [XLEN-1:0] sel_target
);

  always_comb begin
    sel_valid  = 1'b1;
    sel_src    = SRC_ROB;
    sel_target = rob_target;
    if (rob_valid) begin
      sel_src    = SRC_ROB;
      sel_target = rob_target;
    end else if (br_valid && !mask_br) begin
      sel_src    = SRC_BR;
      sel_target = br_target;
    end else if (d1_valid && !mask_low) begin
      sel_src    = SRC_D1;
      sel_target = d1_target;
    end else if (ras_valid && !mask_low) begin
      sel_src    = SRC_RAS;
      sel_target = ras_target;
    end else begin
      sel_valid  = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_arb.sv
// Front-end redirect arbiter: registered redirect pulse with stall hold,
// fetch epoch and post-ROB/BR squash window. FETCH_REDIRECT_STATS_EN adds counters.
module fetch_redirect_arb
  import fetch_redirect_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CLC_WIDTH  = 28,
  parameter int SQUASH_CYC = 3,
  parameter int EPOCH_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 rob_valid,
  input  logic [XLEN-1:0]      rob_target,
  input  logic                 br_valid,
  input  logic [XLEN-1:0]      br_target,
  input  logic                 d1_valid,
  input  logic [XLEN-1:0]      d1_target,
  input  logic                 ras_valid,
  input  logic [XLEN-1:0]      ras_target,
  output logic                 redirect,
  output logic [CLC_WIDTH-1:0] redirect_clc,
  output logic [1:0]           redirect_src,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 squash_active,
`ifdef FETCH_REDIRECT_STATS_EN
  output logic [15:0]          drop_cnt,
  output logic [15:0]          redirect_cnt,
`endif
  output logic                 pending
);

  localparam int CLC_LSB = clc_lsb(XLEN, CLC_WIDTH);

  fsm_state_e           state_q, state_d;
  logic [3:0]           sq_cnt_q, sq_cnt_d, sq_cnt_dec;
  logic                 sq_rob_q, sq_rob_d;
  logic [1:0]           hold_src_q, hold_src_d;
  logic [CLC_WIDTH-1:0] hold_clc_q, hold_clc_d;
  logic                 redirect_q, redirect_d;
  logic [CLC_WIDTH-1:0] clc_q, clc_d;
  logic [1:0]           src_q, src_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;

  logic                 squash_on;
  logic                 cand_vld;
  logic [1:0]           cand_src;
  logic [XLEN-1:0]      cand_tgt;
  logic [CLC_WIDTH-1:0] cand_clc;
  logic                 take_new, have, issue, opens;
  logic [1:0]           sel_src;
  logic [CLC_WIDTH-1:0] sel_clc;

  assign squash_on = (sq_cnt_q != 4'd0);

  redirect_prio_sel #(.XLEN(XLEN)) u_prio_sel (
    .rob_valid  (rob_valid),
    .rob_target (rob_target),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .d1_valid   (d1_valid),
    .d1_target  (d1_target),
    .ras_valid  (ras_valid),
    .ras_target (ras_target),
    .mask_low   (squash_on),
    .mask_br    (squash_on && sq_rob_q),
    .sel_valid  (cand_vld),
    .sel_src    (cand_src),
    .sel_target (cand_tgt)
  );

  // A held redirect yields to an equal-or-higher priority newcomer, so the
  // same source re-requesting while stalled always carries its newest target.
  always_comb begin
    cand_clc   = CLC_WIDTH'(clc_slice(64'(cand_tgt), CLC_LSB));
    take_new   = cand_vld && ((state_q != PEND) || (cand_src <= hold_src_q));
    have       = cand_vld || (state_q == PEND);
    sel_src    = take_new ? cand_src : hold_src_q;
    sel_clc    = take_new ? cand_clc : hold_clc_q;
    issue      = have && !stall_in;
    opens      = issue && (sel_src <= SRC_BR);
    sq_cnt_dec = squash_on ? (sq_cnt_q - 4'd1) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (have && stall_in)                 state_d = PEND;
    else if (opens || sq_cnt_dec != 4'd0) state_d = SQUASH;
  end

  always_comb begin
    sq_cnt_d   = opens ? 4'(SQUASH_CYC) : sq_cnt_dec;
    sq_rob_d   = opens ? (sel_src == SRC_ROB) : sq_rob_q;
    hold_src_d = (have && stall_in) ? sel_src : hold_src_q;
    hold_clc_d = (have && stall_in) ? sel_clc : hold_clc_q;
    redirect_d = issue;
    clc_d      = issue ? sel_clc : clc_q;
    src_d      = issue ? sel_src : src_q;
    epoch_d    = issue ? (epoch_q + EPOCH_W'(1)) : epoch_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_cnt_q   <= 4'd0;
      sq_rob_q   <= 1'b0;
      hold_src_q <= SRC_ROB;
      hold_clc_q <= '0;
      redirect_q <= 1'b0;
      clc_q      <= '0;
      src_q      <= SRC_ROB;
      epoch_q    <= '0;
    end else begin
      sq_cnt_q   <= sq_cnt_d;
      sq_rob_q   <= sq_rob_d;
      hold_src_q <= hold_src_d;
      hold_clc_q <= hold_clc_d;
      redirect_q <= redirect_d;
      clc_q      <= clc_d;
      src_q      <= src_d;
      epoch_q    <= epoch_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_clc  = clc_q;
  assign redirect_src  = src_q;
  assign epoch         = epoch_q;
  assign squash_active = squash_on;
  assign pending       = (state_q == PEND);

`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [2:0]  drop_inc;
  logic [16:0] drop_sum;

  // Each masked request counts once; a PEND contention always loses one side.
  always_comb begin
    drop_inc = 3'(squash_on && d1_valid) + 3'(squash_on && ras_valid)
             + 3'(squash_on && sq_rob_q && br_valid)
             + 3'((state_q == PEND) && cand_vld);
    drop_sum       = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    redirect_cnt_d = (issue && redirect_cnt_q != 16'hFFFF) ? (redirect_cnt_q + 16'd1)
                                                           : redirect_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q     <= '0;
      redirect_cnt_q <= '0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign drop_cnt     = drop_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_arb.sv
// Scoreboard bench for fetch_redirect_arb: directed scenarios plus random
// traffic checked against a behavioural redirect model.
module tb_fetch_redirect_arb;

  localparam int XLEN       = 32;
  localparam int CLC_WIDTH  = 28;
  localparam int SQUASH_CYC = 3;
  localparam int EPOCH_W    = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 stall_in = 1'b0;
  logic                 rob_valid = 1'b0, br_valid = 1'b0, d1_valid = 1'b0, ras_valid = 1'b0;
  logic [XLEN-1:0]      rob_target = '0, br_target = '0, d1_target = '0, ras_target = '0;
  logic                 redirect;
  logic [CLC_WIDTH-1:0] redirect_clc;
  logic [1:0]           redirect_src;
  logic [EPOCH_W-1:0]   epoch;
  logic                 squash_active;
  logic                 pending;

  fetch_redirect_arb #(
    .XLEN(XLEN), .CLC_WIDTH(CLC_WIDTH), .SQUASH_CYC(SQUASH_CYC), .EPOCH_W(EPOCH_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .rob_valid(rob_valid), .rob_target(rob_target),
    .br_valid(br_valid), .br_target(br_target),
    .d1_valid(d1_valid), .d1_target(d1_target),
    .ras_valid(ras_valid), .ras_target(ras_target),
    .redirect(redirect), .redirect_clc(redirect_clc), .redirect_src(redirect_src),
    .epoch(epoch), .squash_active(squash_active), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int             cyc;
    logic [1:0]     src;
    logic [27:0]    clc;
    logic [2:0]     ep;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state
  bit          m_pend;
  int          m_hsrc;
  logic [31:0] m_htgt;
  int          m_sq;
  bit          m_robwin;
  int          m_epoch;
  bit          exp_pend, exp_sq;

  task automatic model_reset();
    m_pend = 0; m_hsrc = 0; m_htgt = '0; m_sq = 0; m_robwin = 0; m_epoch = 0;
    exp_pend = 0; exp_sq = 0;
    sb.delete();
  endtask

  // Evaluates this cycle's requests; a pulse is expected on the following cycle.
  task automatic model_step();
    bit          v[4];
    logic [31:0] tg[4];
    int          cand = -1;
    int          sel = 0;
    logic [31:0] selt = '0;
    bit          have;
    exp_t        e;
    v[0] = rob_valid;
    v[1] = br_valid && !(m_sq > 0 && m_robwin);
    v[2] = d1_valid && (m_sq == 0);
    v[3] = ras_valid && (m_sq == 0);
    tg[0] = rob_target; tg[1] = br_target; tg[2] = d1_target; tg[3] = ras_target;
    for (int i = 3; i >= 0; i--) if (v[i]) cand = i;
    have = m_pend || (cand >= 0);
    if (have) begin
      if (m_pend && !(cand >= 0 && cand <= m_hsrc)) begin
        sel = m_hsrc; selt = m_htgt;
      end else begin
        sel = cand; selt = tg[cand];
      end
    end
    m_sq = (m_sq > 0) ? m_sq - 1 : 0;
    if (have) begin
      if (stall_in) begin
        m_pend = 1; m_hsrc = sel; m_htgt = selt;
      end else begin
        m_pend  = 0;
        m_epoch = (m_epoch + 1) % 8;
        e.cyc = cyc + 1;
        e.src = 2'(sel);
        e.clc = selt[31:4];
        e.ep  = 3'(m_epoch);
        sb.push_back(e);
        if (sel <= 1) begin
          m_sq = SQUASH_CYC;
          m_robwin = (sel == 0);
        end
      end
    end
    exp_pend = m_pend;
    exp_sq   = (m_sq != 0);
  endtask

  task automatic clr_inputs();
    rob_valid = 0; br_valid = 0; d1_valid = 0; ras_valid = 0; stall_in = 0;
    rob_target = $urandom; br_target = $urandom; d1_target = $urandom; ras_target = $urandom;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    chk("pending", pending, exp_pend);
    chk("squash_active", squash_active, exp_sq);
    clr_inputs();
  endtask

  // Monitor: every pulse is matched against the oldest expected redirect.
  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_missing: got none expected pulse at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (redirect) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got src %0d clc %0h expected no pulse (cycle %0d)",
                   redirect_src, redirect_clc, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("pulse_src", redirect_src, e.src);
          chk("pulse_clc", redirect_clc, e.clc);
          chk("pulse_epoch", epoch, e.ep);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    model_reset();
    clr_inputs();
    @(negedge clk);
    chk("rst_redirect", redirect, 0);
    chk("rst_clc", redirect_clc, 0);
    chk("rst_src", redirect_src, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_squash", squash_active, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Single BR redirect with its squash window
    br_valid = 1; br_target = 32'h0000_1230; step();
    chk("br_redirect", redirect, 1);
    chk("br_clc", redirect_clc, 28'h000_0123);
    chk("br_src", redirect_src, 1);
    chk("br_epoch", epoch, 1);
    for (int i = 0; i < 4; i++) step();

    // ROB then D1 inside the squash window
    rob_valid = 1; step();
    d1_valid = 1; step();
    for (int i = 0; i < 4; i++) step();

    // Stall hold of a D1 redirect
    d1_valid = 1; stall_in = 1; step();
    for (int i = 0; i < 4; i++) begin stall_in = 1; step(); end
    step();
    chk("hold_src", redirect_src, 2);
    step();

    // Held RAS replaced by BR; held ROB keeps priority over BR
    ras_valid = 1; stall_in = 1; step();
    br_valid = 1; stall_in = 1; step();
    stall_in = 1; step();
    step();
    chk("replace_src", redirect_src, 1);
    for (int i = 0; i < 4; i++) step();
    rob_valid = 1; stall_in = 1; step();
    br_valid = 1; stall_in = 1; step();
    step();
    chk("keep_rob_src", redirect_src, 0);
    for (int i = 0; i < 4; i++) step();

    // All four sources at once
    rob_valid = 1; br_valid = 1; d1_valid = 1; ras_valid = 1;
    t = rob_target; step();
    chk("simul_src", redirect_src, 0);
    chk("simul_clc", redirect_clc, t[31:4]);
    for (int i = 0; i < 4; i++) step();

    // Reset while a redirect is held
    d1_valid = 1; stall_in = 1; step();
    stall_in = 1; step();
    #2 rst = 1'b0;
    #1;
    chk("pend_rst_redirect", redirect, 0);
    chk("pend_rst_clc", redirect_clc, 0);
    chk("pend_rst_src", redirect_src, 0);
    chk("pend_rst_epoch", epoch, 0);
    chk("pend_rst_squash", squash_active, 0);
    chk("pend_rst_pending", pending, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_inputs();
    step();

    // Epoch wrap over eight spaced redirects
    for (int i = 0; i < 8; i++) begin
      d1_valid = 1; step();
      step();
    end
    chk("epoch_wrap", epoch, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rob_valid = ($urandom_range(0, 9) == 0);
      br_valid  = ($urandom_range(0, 5) == 0);
      d1_valid  = ($urandom_range(0, 3) == 0);
      ras_valid = ($urandom_range(0, 4) == 0);
      stall_in  = ($urandom_range(0, 2) == 0);
      step();
    end

    for (int i = 0; i < 8; i++) step();
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
